// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the calculator control unit and the
// iterative multiply/divide engine.
//   start  : request, only sampled while the engine is idle
//   op     : 2'b01 multiply, 2'b10 divide, others illegal
//   a, b   : operands, latched by the engine on accept
//   busy   : engine is not idle
//   done   : one-cycle completion pulse
//   err    : divide-by-zero flag, held alongside result
//   result : mult product, or {remainder, quotient} for divide
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [2*WIDTH-1:0]   result;

  // Control unit side.
  modport master (
    output start, op, a, b,
    input  busy, done, err, result
  );

  // Engine side.
  modport slave (
    input  start, op, a, b,
    output busy, done, err, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide engine with its own sequencing FSM.
// One shift-add (multiply) or restoring-subtract (divide) step per clock;
// WIDTH steps per operation. Divide by zero completes immediately with err.
// Ports:
//   clock : system clock, all state updates on posedge
//   clear : asynchronous active-low reset
//   bus   : slave side of muldiv_sequencer_if (start/op/a/b in,
//           busy/done/err/result out)
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clock,
  input  logic                clear,
  muldiv_sequencer_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIter = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;

  logic                 legal_op;
  logic                 accept;
  logic                 div_zero;
  logic                 last_step;
  logic                 busy;
  logic                 done;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shrem;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   step_val;

  assign legal_op  = (bus.op == 2'b01) || (bus.op == 2'b10);
  assign accept    = (state_q == StIdle) && bus.start && legal_op;
  assign div_zero  = (bus.op == 2'b10) && (bus.b == '0);
  assign last_step = (count_q == CntW'(WIDTH - 1));

  // One iteration of the active algorithm on the accumulator.
  // Multiply: acc = {upper, multiplier}; add multiplicand into upper when the
  // multiplier LSB is set, then shift {carry, acc} right.
  // Divide: acc = {rem, quo}; shift left, trial-subtract divisor from rem.
  // The extra sign bit on div_trial keeps the shifted remainder's MSB intact.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    div_shrem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = {1'b0, div_shrem} - {2'b00, opb_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH+1]) begin
        step_val = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_val = {div_shrem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_val = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Datapath next-state.
  always_comb begin
    count_d  = count_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    if (accept) begin
      is_div_d = (bus.op == 2'b10);
      opa_d    = bus.a;
      opb_d    = bus.b;
      count_d  = '0;
      acc_d    = (bus.op == 2'b10) ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
      if (div_zero) begin
        result_d = {bus.a, {WIDTH{1'b1}}};
        err_d    = 1'b1;
      end
    end else if (state_q == StIter) begin
      acc_d   = step_val;
      count_d = count_q + CntW'(1);
      if (last_step) begin
        count_d  = '0;
        result_d = step_val;
        err_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q  <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = div_zero ? StDone : StIter;
        end
      end
      StIter: begin
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from state only.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
